// File: rtl/sparse_result_writeback.sv
// Result-tile writeback: buffers one ROWS x COLS accumulator tile and drains it row-major into a BRAM write port.
// Optional requantisation to saturated INT8 is enabled by defining SPARSE_WB_REQUANT_EN.
module sparse_result_writeback #(
    parameter int ROWS   = 2,
    parameter int COLS   = 8,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        res_valid,
    output logic                        res_ready,
    input  logic [ROWS*COLS*ACC_W-1:0]  res_data,
    input  logic [15:0]                 res_block_row,
    input  logic [15:0]                 res_block_col,
    input  logic [ADDR_W-1:0]           cfg_base_addr,
    input  logic [15:0]                 cfg_row_pitch,
    input  logic [4:0]                  cfg_shift,
    input  logic                        clear,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [31:0]                 wr_data,
    output logic                        done_pulse,
    output logic                        busy,
    output logic                        err_addr,
    output logic [31:0]                 blocks_written
);

    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [0:0] {IDLE, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [31:0]         base_q, base_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [31:0]         blocks_q, blocks_d;

    logic [ACC_W-1:0]    elem_in [N];
    logic [ACC_W-1:0]    tile_q  [N];
    logic                handshake;
    logic                last_beat;
    logic [IW-1:0]       idx_inc;
    logic                beat_go;
    logic [IW-1:0]       beat_idx;
    logic [31:0]         beat_base;
    logic [31:0]         beat_addr;
    logic [ACC_W-1:0]    beat_elem;
    logic                in_range;

    assign last_beat = (state_q == DRAIN) && (idx_q == LAST_IDX);
    assign res_ready = (state_q == IDLE) || last_beat;
    assign handshake = res_valid && res_ready;
    assign idx_inc   = idx_q + IW'(1);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_tile
            assign elem_in[gi] = res_data[gi*ACC_W +: ACC_W];

            // Data-only storage: a reset aborts the drain, so stale contents are never read.
            always_ff @(posedge clk) begin
                if (handshake) begin
                    tile_q[gi] <= elem_in[gi];
                end
            end
        end
    endgenerate

`ifdef SPARSE_WB_REQUANT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~ACC_W'(127);
    logic [4:0]              shift_q;
    logic [4:0]              beat_shift;
    logic signed [ACC_W-1:0] shifted;

    always_ff @(posedge clk) begin
        if (handshake) begin
            shift_q <= cfg_shift;
        end
    end
`else
    logic unused_cfg_shift;
    assign unused_cfg_shift = ^cfg_shift;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        base_d    = base_q;
        beat_go   = 1'b0;
        beat_idx  = '0;
        beat_base = base_q;
        beat_elem = '0;
`ifdef SPARSE_WB_REQUANT_EN
        beat_shift = shift_q;
`endif
        if (handshake) begin
            // New tile starts its beat 0 straight from the input bus, so no bubble follows a last beat.
            beat_base = 32'(cfg_base_addr)
                      + 32'(res_block_row) * 32'(cfg_row_pitch)
                      + 32'(res_block_col) * 32'(N);
            beat_elem = elem_in[0];
            beat_go   = 1'b1;
            state_d   = DRAIN;
            idx_d     = '0;
            base_d    = beat_base;
`ifdef SPARSE_WB_REQUANT_EN
            beat_shift = cfg_shift;
`endif
        end else if (state_q == DRAIN && !last_beat) begin
            beat_idx  = idx_inc;
            beat_elem = tile_q[idx_inc];
            beat_go   = 1'b1;
            idx_d     = idx_inc;
        end else if (last_beat) begin
            state_d = IDLE;
            idx_d   = '0;
        end

        beat_addr = beat_base + 32'(beat_idx);
        in_range  = (beat_addr[31:ADDR_W] == '0);
        wr_en_d   = beat_go && in_range;
        wr_addr_d = beat_addr[ADDR_W-1:0];

`ifdef SPARSE_WB_REQUANT_EN
        shifted = $signed(beat_elem) >>> beat_shift;
        if (shifted > SAT_MAX) begin
            wr_data_d = 32'd127;
        end else if (shifted < SAT_MIN) begin
            wr_data_d = 32'hFFFF_FF80;
        end else begin
            wr_data_d = {{24{shifted[7]}}, shifted[7:0]};
        end
`else
        wr_data_d = 32'(beat_elem);
`endif

        done_d   = beat_go && (beat_idx == LAST_IDX);
        err_d    = err_q || (beat_go && !in_range);
        blocks_d = blocks_q + 32'(done_d);
        if (clear) begin
            err_d    = 1'b0;
            blocks_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            base_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            blocks_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            base_q    <= base_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            blocks_q  <= blocks_d;
        end
    end

    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign done_pulse     = done_q;
    assign busy           = (state_q != IDLE);
    assign err_addr       = err_q;
    assign blocks_written = blocks_q;

endmodule

// File: doc/sparse_result_writeback.md
# sparse_result_writeback

Downstream stage of the sparse systolic array. Accepts one 2×8 INT32 result tile per valid/ready handshake, buffers it, and drains it one 32-bit word per cycle into the output BRAM write port at an address derived from the tile's block coordinates. Replaces the single-word store in the sparse top level and reports per-tile completion and address-range errors.

## Interface
- ROWS, 2, result tile rows (PE rows)
- COLS, 8, result tile columns
- ACC_W, 32, accumulator width per element
- ADDR_W, 10, output BRAM word-address width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- res_valid  in  1  result tile valid
- res_ready  out  1  block can accept a tile
- res_data  in  ROWS*COLS*ACC_W  flattened tile; element (r,c) at bits [(r*COLS+c)*ACC_W +: ACC_W]
- res_block_row  in  16  tile block-row index
- res_block_col  in  16  tile block-col index
- cfg_base_addr  in  ADDR_W  output region base word address
- cfg_row_pitch  in  16  words per block row
- cfg_shift  in  5  requant right shift; used only with the macro
- clear  in  1  sync pulse: clears err_addr and blocks_written
- wr_en  out  1  BRAM write strobe
- wr_addr  out  ADDR_W  BRAM word address
- wr_data  out  32  BRAM write data
- done_pulse  out  1  one cycle at last drain beat of each tile
- busy  out  1  state != IDLE
- err_addr  out  1  sticky out-of-range flag
- blocks_written  out  32  tiles completed

## Operation
- States: IDLE, DRAIN. Reset: IDLE, idx=0, all registered outputs 0.
- res_ready = (state==IDLE) || (state==DRAIN && idx==ROWS*COLS-1). Handshake = res_valid && res_ready.
- On handshake: capture res_data into tile buffer; compute tile base B = cfg_base_addr + res_block_row*cfg_row_pitch + res_block_col*ROWS*COLS in 32-bit unsigned arithmetic (config sampled only here); idx←0; state←DRAIN.
- DRAIN beat idx: element (idx/COLS, idx%COLS), row-major. Full address A = B + idx.
- A < 2^ADDR_W: wr_en=1, wr_addr=A[ADDR_W-1:0]. Otherwise wr_en=0, err_addr←1; drain continues.
- Last beat (idx=ROWS*COLS-1): done_pulse=1, blocks_written++; with a handshake in the same cycle, go straight to new tile's beat 0 (no bubble), else IDLE.
- clear and done_pulse in same cycle: clear wins; blocks_written=0, err_addr=0.
- Mid-drain reset: abort immediately, no further writes, buffer contents discarded.
- blocks_written wraps 2^32-1 → 0.

## Timing
- Outputs wr_en/wr_addr/wr_data/done_pulse are registered: beat 0 appears the cycle after handshake.
- Latency handshake → first write: 1 cycle; → done_pulse: ROWS*COLS cycles (16).
- Sustained throughput: one tile per ROWS*COLS cycles with res_valid held high.
- res_ready depends only on state/idx, never combinationally on res_valid.
- res_valid while res_ready=0: tile must remain stable upstream; not sampled.

## Configuration
- SPARSE_WB_REQUANT_EN defined: wr_data = sign-extend to 32 bits of sat8(element >>> cfg_shift); arithmetic shift (floor), saturate to [-128,127]. Adds no latency.
- Undefined: wr_data = raw ACC_W element; cfg_shift ignored.

## Test plan
- Single tile, base=0, pitch=64, row=0, col=0, elements 0..15 → 16 writes addr 0..15 data 0..15, done_pulse at 16th, blocks_written=1, err_addr=0.
- Tile at row=2, col=1, base=100, pitch=64 → addresses 244..259, row-major order of elements.
- Back-to-back: res_valid held high for 3 tiles → 48 consecutive wr_en cycles, no bubble, blocks_written=3.
- Range overflow: ADDR_W=10, base=1016, row=0, col=0 → writes 1016..1023 (8), beats 8..15 suppressed, err_addr=1; clear → err_addr=0.
- Reset asserted at beat 5 → wr_en=0 immediately, busy=0, res_ready=1 after release, blocks_written=0.
- With SPARSE_WB_REQUANT_EN, cfg_shift=4: elements 4096, -4096, 160, -33 → wr_data 127, -128 (0xFFFFFF80), 10, -3 (0xFFFFFFFD).
